// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
// Streaming 2x2 / stride-2 max pooling over three parallel IEEE-754 channels.
// Pixels arrive in raster order, one per channel per accepted beat. Each channel
// keeps the even-column pixel in a hold register and the horizontal pair maximum
// of each even row in a half-row line buffer. On the odd-row / odd-column beat
// that completes a window, the pooled value is registered and presented one
// cycle later. The design never stalls.
module maxpool2x2_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int IFM_SIZE   = 28,
   parameter int NUM_CH     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in_from_previous1,
   input  logic [DATA_WIDTH-1:0] data_in_from_previous2,
   input  logic [DATA_WIDTH-1:0] data_in_from_previous3,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out_for_next1,
   output logic [DATA_WIDTH-1:0] data_out_for_next2,
   output logic [DATA_WIDTH-1:0] data_out_for_next3,
   output logic                  frame_done
);

   localparam int HALF = IFM_SIZE / 2;
   localparam int CW   = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

   // Floating-point maximum evaluated directly on the bit patterns.
   // Mixed signs pick the positive operand, so +0 wins over -0.
   function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] r;
      if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
         r = a[DATA_WIDTH-1] ? b : a;
      else if (!a[DATA_WIDTH-1])
         r = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
      else
         r = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
      return r;
   endfunction

   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          col_last, row_last;
   logic          win_done;
   logic [AW-1:0] lb_addr;

   assign col_last = (col_q == CW'(IFM_SIZE - 1));
   assign row_last = (row_q == CW'(IFM_SIZE - 1));
   assign win_done = valid_in & row_q[0] & col_q[0];
   assign lb_addr  = AW'(col_q >> 1);

   // Raster position counters; they advance only on accepted beats and wrap at the end of a map.
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      valid_d = win_done;
      done_d  = win_done & col_last & row_last;
      if (valid_in) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Control state: counters and output strobes, cleared by reset (which also drops a coincident beat).
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign valid_out  = valid_q;
   assign frame_done = done_q;

   logic [DATA_WIDTH-1:0] din  [NUM_CH];
   logic [DATA_WIDTH-1:0] dout [NUM_CH];

   assign din[0] = data_in_from_previous1;
   assign din[1] = data_in_from_previous2;
   assign din[2] = data_in_from_previous3;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] hold_q, hold_d;
         logic [DATA_WIDTH-1:0] dout_q, dout_d;
         logic [DATA_WIDTH-1:0] lb_mem [HALF];
         logic [DATA_WIDTH-1:0] lb_rd_q;
         logic [DATA_WIDTH-1:0] pair_max;
         logic [DATA_WIDTH-1:0] win_max;

         assign pair_max = fmax(hold_q, din[gi]);
         assign win_max  = fmax(lb_rd_q, pair_max);

         // Capture the even-column pixel and the completed window result.
         always_comb begin
            hold_d = hold_q;
            dout_d = dout_q;
            if (valid_in && !col_q[0])
               hold_d = din[gi];
            if (win_done)
               dout_d = win_max;
         end

         // Hold and output registers; output keeps its last value between pooled beats.
         always_ff @(posedge clk) begin
            if (reset) begin
               hold_q <= '0;
               dout_q <= '0;
            end else begin
               hold_q <= hold_d;
               dout_q <= dout_d;
            end
         end

         // Half-row line buffer: even rows store pair maxima; odd rows prefetch the entry on the
         // even-column beat so the registered read is ready when the odd column completes the window.
         always_ff @(posedge clk) begin
            if (valid_in && !reset && col_q[0] && !row_q[0])
               lb_mem[lb_addr] <= pair_max;
            if (valid_in && !reset && !col_q[0] && row_q[0])
               lb_rd_q <= lb_mem[lb_addr];
         end

         assign dout[gi] = dout_q;
      end
   endgenerate

   assign data_out_for_next1 = dout[0];
   assign data_out_for_next2 = dout[1];
   assign data_out_for_next3 = dout[2];

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 4x4 instance for the directed cases and a 28x28 instance
// for the randomized float frame. Expected pooled beats are queued when their completing input
// beat is accepted and checked when the DUT presents them.
module tb_maxpool2x2_stream;

   typedef struct {
      int          cyc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] d3;
      logic        fd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        vin4, vin28;
   logic [31:0] d1, d2, d3;
   logic        vo4, fd4, vo28, fd28;
   logic [31:0] o4_1, o4_2, o4_3, o28_1, o28_2, o28_3;

   int          cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   exp_t        q4[$];
   exp_t        q28[$];
   exp_t        last4, last28;
   int          fd_seen4 = 0, fd_seen28 = 0, fd_exp4 = 0, fd_exp28 = 0;
   logic [31:0] pix [3][784];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   maxpool2x2_stream #(.DATA_WIDTH(32), .IFM_SIZE(4), .NUM_CH(3)) dut4 (
      .clk(clk), .reset(reset), .valid_in(vin4),
      .data_in_from_previous1(d1), .data_in_from_previous2(d2), .data_in_from_previous3(d3),
      .valid_out(vo4), .data_out_for_next1(o4_1), .data_out_for_next2(o4_2),
      .data_out_for_next3(o4_3), .frame_done(fd4));

   maxpool2x2_stream #(.DATA_WIDTH(32), .IFM_SIZE(28), .NUM_CH(3)) dut28 (
      .clk(clk), .reset(reset), .valid_in(vin28),
      .data_in_from_previous1(d1), .data_in_from_previous2(d2), .data_in_from_previous3(d3),
      .valid_out(vo28), .data_out_for_next1(o28_1), .data_out_for_next2(o28_2),
      .data_out_for_next3(o28_3), .frame_done(fd28));

   // Total order on float bit patterns: map each pattern to an unsigned key.
   function automatic logic [31:0] okey(input logic [31:0] x);
      return x[31] ? ~x : {1'b1, x[30:0]};
   endfunction

   function automatic logic [31:0] win_max(input int ch, input int n, input int r, input int c);
      logic [31:0] best, v;
      best = pix[ch][(r-1)*n + (c-1)];
      for (int k = 1; k < 4; k++) begin
         v = pix[ch][(r-1+k/2)*n + (c-1+k%2)];
         if (okey(v) > okey(best)) best = v;
      end
      return best;
   endfunction

   // Per-cycle monitor on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         bit   ex;
         exp_t e;
         ex = (q4.size() != 0) && (q4[0].cyc == cyc);
         if (fd4) fd_seen4++;
         if (fd28) fd_seen28++;
         n_assert++;
         assert (vo4 === ex) else begin
            n_fail++; $error("FAIL valid_out4 cyc=%0d observed=%0b expected=%0b", cyc, vo4, ex);
         end
         if (ex) begin
            e = q4.pop_front();
            last4 = e;
         end else begin
            e = last4;
            e.fd = 1'b0;
         end
         n_assert++;
         assert ({o4_1, o4_2, o4_3, fd4} === {e.d1, e.d2, e.d3, e.fd}) else begin
            n_fail++; $error("FAIL data4 cyc=%0d observed=%h/%h/%h fd=%0b expected=%h/%h/%h fd=%0b",
                             cyc, o4_1, o4_2, o4_3, fd4, e.d1, e.d2, e.d3, e.fd);
         end
         ex = (q28.size() != 0) && (q28[0].cyc == cyc);
         n_assert++;
         assert (vo28 === ex) else begin
            n_fail++; $error("FAIL valid_out28 cyc=%0d observed=%0b expected=%0b", cyc, vo28, ex);
         end
         if (ex) begin
            e = q28.pop_front();
            last28 = e;
         end else begin
            e = last28;
            e.fd = 1'b0;
         end
         n_assert++;
         assert ({o28_1, o28_2, o28_3, fd28} === {e.d1, e.d2, e.d3, e.fd}) else begin
            n_fail++; $error("FAIL data28 cyc=%0d observed=%h/%h/%h fd=%0b expected=%h/%h/%h fd=%0b",
                             cyc, o28_1, o28_2, o28_3, fd28, e.d1, e.d2, e.d3, e.fd);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         vin4 = 1'b0; vin28 = 1'b0;
         d1 = $urandom; d2 = $urandom; d3 = $urandom;
         @(posedge clk); #1;
      end
   endtask

   task automatic clear_last();
      last4  = '{cyc: 0, d1: 32'h0, d2: 32'h0, d3: 32'h0, fd: 1'b0};
      last28 = last4;
   endtask

   // Reset pulse; optionally offers a beat in the same cycle, which must be dropped.
   task automatic do_reset(input bit with_beat);
      reset = 1'b1;
      vin4 = with_beat; vin28 = 1'b0;
      d1 = 32'h4000_0000; d2 = 32'h4100_0000; d3 = 32'h4200_0000;
      @(posedge clk); #1;
      reset = 1'b0; vin4 = 1'b0;
      clear_last();
      $display("reset pulse (beat offered=%0b) at cyc %0d", with_beat, cyc);
   endtask

   task automatic fill_ramp(input int base);
      for (int i = 0; i < 16; i++) begin
         pix[0][i] = base + i + 1;
         pix[1][i] = base + i + 101;
         pix[2][i] = 32'h0;
      end
   endtask

   // Drives nbeats pixels of the current map in raster order, queueing each completed window.
   task automatic send_beats(input bit big, input int maxgap, input int nbeats);
      int   n;
      exp_t e;
      n = big ? 28 : 4;
      for (int i = 0; i < nbeats; i++) begin
         int r, c;
         r = i / n; c = i % n;
         if (maxgap > 0) idle($urandom_range(maxgap, 0));
         d1 = pix[0][i]; d2 = pix[1][i]; d3 = pix[2][i];
         vin4 = !big; vin28 = big;
         @(posedge clk); #1;
         vin4 = 1'b0; vin28 = 1'b0;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.cyc = cyc;
            e.d1  = win_max(0, n, r, c);
            e.d2  = win_max(1, n, r, c);
            e.d3  = win_max(2, n, r, c);
            e.fd  = (r == n - 1) && (c == n - 1);
            if (big) begin
               q28.push_back(e);
               if (e.fd) fd_exp28++;
            end else begin
               q4.push_back(e);
               if (e.fd) fd_exp4++;
            end
            $display("N=%0d pooled (%0d,%0d) expect %h %h %h fd=%0b at cyc %0d",
                     n, r / 2, c / 2, e.d1, e.d2, e.d3, e.fd, e.cyc);
         end
      end
   endtask

   initial begin
      reset = 1'b1; vin4 = 1'b0; vin28 = 1'b0;
      d1 = '0; d2 = '0; d3 = '0;
      clear_last();
      @(posedge clk); #1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      reset = 1'b0;
      idle(2);

      // 1: contiguous frame
      fill_ramp(0);
      send_beats(1'b0, 0, 16);
      idle(3);

      // 2: same frame with random gaps
      send_beats(1'b0, 3, 16);
      idle(3);

      // 3: sign handling (ch1 windows 0/1 from the sign cases, ch2 all negative)
      fill_ramp(0);
      pix[0][0] = 32'hBF80_0000; pix[0][1] = 32'h8000_0000;
      pix[0][4] = 32'hC000_0000; pix[0][5] = 32'hBF00_0000;
      pix[0][2] = 32'h8000_0000; pix[0][3] = 32'h0000_0000;
      pix[0][6] = 32'hBF80_0000; pix[0][7] = 32'hC000_0000;
      for (int i = 0; i < 16; i++) pix[1][i] = 32'hBF80_0000 + 32'(i * 32'h0010_0000);
      send_beats(1'b0, 1, 16);
      idle(2);

      // 4: two frames back to back
      fill_ramp(0);
      send_beats(1'b0, 0, 16);
      fill_ramp(16);
      send_beats(1'b0, 0, 16);
      idle(3);

      // 5: reset mid-frame (beats 0..9 sent), beat coincident with reset dropped, then full frame
      fill_ramp(0);
      send_beats(1'b0, 0, 10);
      do_reset(1'b1);
      idle(2);
      send_beats(1'b0, 0, 16);
      idle(3);

      // 6: 28x28 random non-negative finite floats
      for (int i = 0; i < 784; i++)
         for (int ch = 0; ch < 3; ch++)
            pix[ch][i] = {1'b0, 8'($urandom_range(254, 0)), 23'($urandom)};
      send_beats(1'b1, 1, 784);
      idle(4);

      n_assert++;
      assert (q4.size() == 0 && q28.size() == 0) else begin
         n_fail++; $error("FAIL drain observed=%0d/%0d pending expected=0/0", q4.size(), q28.size());
      end
      n_assert++;
      assert (fd_seen4 == fd_exp4 && fd_seen28 == fd_exp28) else begin
         n_fail++; $error("FAIL frame_done_count observed=%0d/%0d expected=%0d/%0d",
                          fd_seen4, fd_seen28, fd_exp4, fd_exp28);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
